writeback_queue: RTL and testbench

//  Writer side of the register bank write port (w_en / r_write / w_data).

---
 rtl/writeback_queue_if.sv | 41 ++++
 rtl/writeback_queue.sv | 125 ++++++++++++
 tb/tb_writeback_queue.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/writeback_queue_if.sv
// Bundle for the writeback queue: producer push port, bank write port,
// decode-side hazard/forward lookup and the occupancy count.
// master = the surrounding pipeline, slave = the queue itself.
interface writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              wb_grant;
    logic              w_en;
    logic [ADDR_W-1:0] r_write;
    logic [DATA_W-1:0] w_data;
    logic [ADDR_W-1:0] r_op_a;
    logic [ADDR_W-1:0] r_op_b;
    logic              pend_a;
    logic              pend_b;
    logic              fwd_a_valid;
    logic [DATA_W-1:0] fwd_a_data;
    logic              fwd_b_valid;
    logic [DATA_W-1:0] fwd_b_data;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_rd, in_data, flush, wb_grant, r_op_a, r_op_b,
        input  in_ready, w_en, r_write, w_data, pend_a, pend_b,
               fwd_a_valid, fwd_a_data, fwd_b_valid, fwd_b_data, count
    );

    modport slave (
        input  in_valid, in_rd, in_data, flush, wb_grant, r_op_a, r_op_b,
        output in_ready, w_en, r_write, w_data, pend_a, pend_b,
               fwd_a_valid, fwd_a_data, fwd_b_valid, fwd_b_data, count
    );
endinterface

// File: rtl/writeback_queue.sv
// In-order writeback FIFO feeding the register bank write port.
// Drains one entry per granted cycle, flags pending writes for the two decode
// read indices and, with WB_QUEUE_FWD_EN defined, forwards the youngest queued
// value for each. Without WB_QUEUE_FWD_EN the forward outputs are tied to 0.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    writeback_queue_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Pointers carry one wrap bit above the slot index so full and empty differ.
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [PTR_W-1:0]  used;
    logic              empty, full;
    logic              push_fire, store, pop;

    logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DEPTH-1:0]  occ, match_a, match_b;

    assign wr_idx = wr_ptr_q[IDX_W-1:0];
    assign rd_idx = rd_ptr_q[IDX_W-1:0];
    assign used   = wr_ptr_q - rd_ptr_q;
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

    // in_ready is forced low while reset is held, independent of pointer state.
    assign bus.in_ready = rst_n & ~full;
    assign push_fire    = bus.in_valid & bus.in_ready & ~bus.flush;
    // Writes to x0 complete the handshake but never occupy a slot.
    assign store        = push_fire & (bus.in_rd != '0);
    assign pop          = ~empty & bus.wb_grant & ~bus.flush;

    assign bus.w_en    = pop;
    assign bus.r_write = rd_mem_q[rd_idx];
    assign bus.w_data  = data_mem_q[rd_idx];
    assign bus.count   = CNT_W'(used);

    // Pointer next state: flush discards everything, otherwise pop and push advance independently.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
            if (store) wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [IDX_W-1:0] age;

            // Slot storage; cleared on reset so the head reads as zero afterwards.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_mem_q[gi]   <= '0;
                    data_mem_q[gi] <= '0;
                end else if (store && (wr_idx == IDX_W'(gi))) begin
                    rd_mem_q[gi]   <= bus.in_rd;
                    data_mem_q[gi] <= bus.in_data;
                end
            end

            // A slot is live when its distance from the head is below the fill level.
            assign age         = IDX_W'(gi) - rd_idx;
            assign occ[gi]     = ({1'b0, age} < used);
            assign match_a[gi] = occ[gi] && (rd_mem_q[gi] == bus.r_op_a);
            assign match_b[gi] = occ[gi] && (rd_mem_q[gi] == bus.r_op_b);
        end
    endgenerate

    assign bus.pend_a = (bus.r_op_a != '0) && (|match_a);
    assign bus.pend_b = (bus.r_op_b != '0) && (|match_b);

`ifdef WB_QUEUE_FWD_EN
    logic [DATA_W-1:0] fwd_a_c, fwd_b_c;
    logic [IDX_W-1:0]  scan_idx;

    // Walk slots oldest to youngest; the last hit is the youngest matching write.
    always_comb begin
        fwd_a_c  = '0;
        fwd_b_c  = '0;
        scan_idx = rd_idx;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_idx + IDX_W'(k);
            if (match_a[scan_idx]) fwd_a_c = data_mem_q[scan_idx];
            if (match_b[scan_idx]) fwd_b_c = data_mem_q[scan_idx];
        end
    end

    assign bus.fwd_a_valid = bus.pend_a;
    assign bus.fwd_b_valid = bus.pend_b;
    assign bus.fwd_a_data  = fwd_a_c;
    assign bus.fwd_b_data  = fwd_b_c;
`else
    assign bus.fwd_a_valid = 1'b0;
    assign bus.fwd_b_valid = 1'b0;
    assign bus.fwd_a_data  = '0;
    assign bus.fwd_b_data  = '0;
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed vector table, reset and flush/wrap
// sequences, then randomized traffic against a queue-based reference model.
module tb_writeback_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    writeback_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t mq[$];

    typedef struct {
        logic iv; logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] data; logic gr;
        logic [ADDR_W-1:0] oa; logic [ADDR_W-1:0] ob;
        int cnt; logic rdy; logic wen; logic [ADDR_W-1:0] wr; logic [DATA_W-1:0] wd;
        logic pa; logic pb; logic [DATA_W-1:0] fa;
    } vec_t;

    vec_t vt[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d,
                         input logic fl, input logic gr, input logic [ADDR_W-1:0] oa,
                         input logic [ADDR_W-1:0] ob);
        bus.in_valid = iv;  bus.in_rd = rd;   bus.in_data = d;
        bus.flush    = fl;  bus.wb_grant = gr;
        bus.r_op_a   = oa;  bus.r_op_b = ob;
    endtask

    function automatic logic m_pend(input logic [ADDR_W-1:0] op);
        if (op == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DATA_W-1:0] m_fwd(input logic [ADDR_W-1:0] op);
        logic [DATA_W-1:0] v = '0;
        if (op == 0) return '0;
        foreach (mq[i]) if (mq[i].rd == op) v = mq[i].data;
        return v;
    endfunction

    // One clock of traffic checked against the reference model.
    task automatic cycle_model(input logic iv, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d,
                               input logic fl, input logic gr, input logic [ADDR_W-1:0] oa,
                               input logic [ADDR_W-1:0] ob);
        logic exp_wen, exp_full;
        @(posedge clk); #1;
        drive(iv, rd, d, fl, gr, oa, ob);
        @(negedge clk);
        exp_full = (mq.size() == DEPTH);
        exp_wen  = (mq.size() != 0) && gr && !fl;
        chk("count", 64'(bus.count), 64'(mq.size()));
        chk("in_ready", 64'(bus.in_ready), 64'(!exp_full));
        chk("w_en", 64'(bus.w_en), 64'(exp_wen));
        if (exp_wen) begin
            chk("r_write", 64'(bus.r_write), 64'(mq[0].rd));
            chk("w_data", 64'(bus.w_data), 64'(mq[0].data));
        end
        chk("pend_a", 64'(bus.pend_a), 64'(m_pend(oa)));
        chk("pend_b", 64'(bus.pend_b), 64'(m_pend(ob)));
`ifdef WB_QUEUE_FWD_EN
        chk("fwd_a_valid", 64'(bus.fwd_a_valid), 64'(m_pend(oa)));
        chk("fwd_b_valid", 64'(bus.fwd_b_valid), 64'(m_pend(ob)));
        if (m_pend(oa)) chk("fwd_a_data", 64'(bus.fwd_a_data), 64'(m_fwd(oa)));
        if (m_pend(ob)) chk("fwd_b_data", 64'(bus.fwd_b_data), 64'(m_fwd(ob)));
`else
        chk("fwd_a_valid", 64'(bus.fwd_a_valid), 64'(0));
        chk("fwd_b_data", 64'(bus.fwd_b_data), 64'(0));
`endif
        $display("cyc iv=%0d rd=%0d fl=%0d gr=%0d -> cnt=%0d wen=%0d", iv, rd, fl, gr, bus.count, bus.w_en);
        if (fl) mq.delete();
        else begin
            if (exp_wen) void'(mq.pop_front());
            if (iv && !exp_full && rd != 0) mq.push_back('{rd, d});
        end
    endtask

    initial begin
        // iv rd data gr oa ob | cnt rdy wen wr wd pa pb fa
        vt[0]  = '{1, 1, 32'h11,   0, 1, 2, 0, 1, 0, 0, 0,      0, 0, 0};
        vt[1]  = '{1, 2, 32'h22,   0, 1, 2, 1, 1, 0, 0, 0,      1, 0, 32'h11};
        vt[2]  = '{1, 3, 32'h33,   0, 1, 2, 2, 1, 0, 0, 0,      1, 1, 32'h11};
        vt[3]  = '{1, 4, 32'h44,   0, 1, 2, 3, 1, 0, 0, 0,      1, 1, 32'h11};
        vt[4]  = '{1, 5, 32'h99,   0, 4, 5, 4, 0, 0, 0, 0,      1, 0, 32'h44};
        vt[5]  = '{0, 0, 0,        1, 1, 4, 4, 0, 1, 1, 32'h11, 1, 1, 32'h11};
        vt[6]  = '{0, 0, 0,        1, 1, 4, 3, 1, 1, 2, 32'h22, 0, 1, 0};
        vt[7]  = '{0, 0, 0,        1, 1, 4, 2, 1, 1, 3, 32'h33, 0, 1, 0};
        vt[8]  = '{0, 0, 0,        1, 1, 4, 1, 1, 1, 4, 32'h44, 0, 1, 0};
        vt[9]  = '{0, 0, 0,        1, 1, 4, 0, 1, 0, 0, 0,      0, 0, 0};
        vt[10] = '{1, 0, 32'hDEAD, 1, 0, 5, 0, 1, 0, 0, 0,      0, 0, 0};
        vt[11] = '{1, 5, 32'h55,   1, 0, 5, 0, 1, 0, 0, 0,      0, 0, 0};
        vt[12] = '{0, 0, 0,        1, 5, 0, 1, 1, 1, 5, 32'h55, 1, 0, 32'h55};
        vt[13] = '{0, 0, 0,        1, 5, 5, 0, 1, 0, 0, 0,      0, 0, 0};
        vt[14] = '{1, 7, 32'hA,    0, 7, 0, 0, 1, 0, 0, 0,      0, 0, 0};
        vt[15] = '{1, 7, 32'hB,    0, 7, 0, 1, 1, 0, 0, 0,      1, 0, 32'hA};
        vt[16] = '{0, 0, 0,        0, 7, 0, 2, 1, 0, 0, 0,      1, 0, 32'hB};
        vt[17] = '{0, 0, 0,        1, 7, 0, 2, 1, 1, 7, 32'hA,  1, 0, 32'hB};
        vt[18] = '{0, 0, 0,        1, 7, 0, 1, 1, 1, 7, 32'hB,  1, 0, 32'hB};
        vt[19] = '{0, 0, 0,        0, 7, 0, 0, 1, 0, 0, 0,      0, 0, 0};

        drive(0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count", 64'(bus.count), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_w_en", 64'(bus.w_en), 64'(0));
        chk("rst_w_data", 64'(bus.w_data), 64'(0));
        chk("rst_r_write", 64'(bus.r_write), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors: stall/fill, x0 drop, hazard and forwarding.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            drive(vt[i].iv, vt[i].rd, vt[i].data, 1'b0, vt[i].gr, vt[i].oa, vt[i].ob);
            @(negedge clk);
            $display("vec %0d: cnt=%0d rdy=%0d wen=%0d wr=%0d wd=%0h pa=%0d pb=%0d",
                     i, bus.count, bus.in_ready, bus.w_en, bus.r_write, bus.w_data, bus.pend_a, bus.pend_b);
            chk("vec_count", 64'(bus.count), 64'(vt[i].cnt));
            chk("vec_in_ready", 64'(bus.in_ready), 64'(vt[i].rdy));
            chk("vec_w_en", 64'(bus.w_en), 64'(vt[i].wen));
            if (vt[i].wen) begin
                chk("vec_r_write", 64'(bus.r_write), 64'(vt[i].wr));
                chk("vec_w_data", 64'(bus.w_data), 64'(vt[i].wd));
            end
            chk("vec_pend_a", 64'(bus.pend_a), 64'(vt[i].pa));
            chk("vec_pend_b", 64'(bus.pend_b), 64'(vt[i].pb));
`ifdef WB_QUEUE_FWD_EN
            chk("vec_fwd_a_valid", 64'(bus.fwd_a_valid), 64'(vt[i].pa));
            if (vt[i].pa) chk("vec_fwd_a_data", 64'(bus.fwd_a_data), 64'(vt[i].fa));
`else
            chk("vec_fwd_a_valid", 64'(bus.fwd_a_valid), 64'(0));
            chk("vec_fwd_a_data", 64'(bus.fwd_a_data), 64'(0));
`endif
        end

        // Flush + wrap: push/pop through the pointers, queue two, flush with a push pending.
        mq.delete();
        for (int i = 0; i < 6; i++) cycle_model(1, 5'(8 + i), 32'(i + 1), 0, 1, 9, 10);
        cycle_model(0, 0, 0, 0, 1, 0, 0);
        cycle_model(1, 10, 32'h100, 0, 0, 10, 11);
        cycle_model(1, 11, 32'h101, 0, 0, 10, 11);
        cycle_model(1, 12, 32'h102, 1, 1, 10, 11);
        chk("flush_no_write", 64'(bus.w_en), 64'(0));
        for (int i = 0; i < 3; i++) cycle_model(0, 0, 0, 0, 1, 12, 10);

        // Reset mid-stream with three entries queued.
        for (int i = 0; i < 3; i++) cycle_model(1, 5'(1 + i), 32'(32'hC0 + i), 0, 0, 1, 2);
        @(posedge clk); #1;
        drive(1, 4, 32'hFF, 0, 1, 1, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 64'(bus.count), 64'(0));
        chk("mid_rst_w_en", 64'(bus.w_en), 64'(0));
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("mid_rst_pend_a", 64'(bus.pend_a), 64'(0));
        chk("mid_rst_w_data", 64'(bus.w_data), 64'(0));
        mq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle_model(0, 0, 0, 0, 1, 1, 2);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            cycle_model($urandom_range(1, 0) == 1,
                        5'($urandom_range(7, 0)),
                        $urandom,
                        $urandom_range(15, 0) == 0,
                        $urandom_range(9, 0) < 6,
                        5'($urandom_range(7, 0)),
                        5'($urandom_range(7, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
